// File: rtl/q4_pkg.sv
// Shared types and golden decode for the Q4 nibble-select exhaustive checker.
package q4_pkg;

    typedef enum logic [1:0] {IDLE, APPLY, CHECK, DONE} q4_state_t;

    localparam int unsigned NUM_VECTORS = 256;

    // All-ones upper nibble selects bit 3; any other non-zero nibble selects bit 2.
    function automatic logic [7:0] q4_golden(input logic [7:0] v);
        if (&v[7:4]) begin
            return {7'b0, v[3]};
        end else if (|v[7:4]) begin
            return {7'b0, v[2]};
        end else begin
            return {6'b0, v[1:0]};
        end
    endfunction

endpackage

// File: rtl/q4_golden_model.sv
// Combinational wrapper around the golden decode.
module q4_golden_model
    import q4_pkg::*;
(
    input  logic [7:0] v_i,
    output logic [7:0] g_o
);

    assign g_o = q4_golden(v_i);

endmodule

// File: rtl/q4_exhaustive_checker.sv
// Sweeps all 256 input vectors through the Q4 circuit and scores each response.
module q4_exhaustive_checker
    import q4_pkg::*;
#(
    parameter int unsigned SETTLE_CYCLES = 1,
    parameter int unsigned ERR_W         = 9
) (
    input  logic             clk,
    input  logic             clear,
    input  logic             start,
    input  logic [7:0]       dut_output,
    output logic [7:0]       dut_input,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [ERR_W-1:0] err_count,
    output logic [7:0]       first_fail_vec,
    output logic             first_fail_valid
);

    localparam int unsigned CNT_W    = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [7:0]  LAST_VEC = 8'(NUM_VECTORS - 1);

    q4_state_t        state_q, state_d;
    logic [7:0]       vec_q, vec_d;
    logic [CNT_W-1:0] settle_q, settle_d;
    logic [ERR_W-1:0] err_q, err_d;
    logic [7:0]       ffv_q, ffv_d;
    logic             ffvalid_q, ffvalid_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             pass_q, pass_d;

    logic [7:0]       golden;
    logic             settle_last;
    logic             mismatch;

    q4_golden_model u_golden (
        .v_i (vec_q),
        .g_o (golden)
    );

    assign settle_last = (settle_q == CNT_W'(SETTLE_CYCLES - 1));
    assign mismatch    = (state_q == CHECK) && (dut_output != golden);

    always_ff @(posedge clk) begin
        if (clear) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE, DONE: if (start) state_d = APPLY;
            APPLY:      if (settle_last) state_d = CHECK;
            CHECK:      state_d = (vec_q == LAST_VEC) ? DONE : APPLY;
            default:    state_d = IDLE;
        endcase
    end

    always_comb begin
        vec_d     = vec_q;
        settle_d  = settle_q;
        err_d     = err_q;
        ffv_d     = ffv_q;
        ffvalid_d = ffvalid_q;
        busy_d    = busy_q;
        done_d    = done_q;
        pass_d    = pass_q;
        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    vec_d     = '0;
                    settle_d  = '0;
                    err_d     = '0;
                    ffv_d     = '0;
                    ffvalid_d = 1'b0;
                    busy_d    = 1'b1;
                    done_d    = 1'b0;
                    pass_d    = 1'b0;
                end
            end
            APPLY: begin
                settle_d = settle_last ? '0 : settle_q + 1'b1;
            end
            CHECK: begin
                if (mismatch) begin
                    if (err_q != '1) err_d = err_q + 1'b1;
                    if (!ffvalid_q) begin
                        ffv_d     = vec_q;
                        ffvalid_d = 1'b1;
                    end
                end
                // Terminate on the explicit last vector so the counter never wraps.
                if (vec_q == LAST_VEC) begin
                    busy_d = 1'b0;
                    done_d = 1'b1;
                    pass_d = (err_d == '0);
                end else begin
                    vec_d = vec_q + 8'd1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (clear) begin
            vec_q     <= '0;
            settle_q  <= '0;
            err_q     <= '0;
            ffv_q     <= '0;
            ffvalid_q <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            pass_q    <= 1'b0;
        end else begin
            vec_q     <= vec_d;
            settle_q  <= settle_d;
            err_q     <= err_d;
            ffv_q     <= ffv_d;
            ffvalid_q <= ffvalid_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            pass_q    <= pass_d;
        end
    end

    assign dut_input        = vec_q;
    assign busy             = busy_q;
    assign done             = done_q;
    assign pass             = pass_q;
    assign err_count        = err_q;
    assign first_fail_vec   = ffv_q;
    assign first_fail_valid = ffvalid_q;

endmodule
